// File: rtl/hrange_stepped_if.sv
// Argument/handshake bundle for the stepped range generator.
// master drives arguments and _ready; slave (the generator) drives the item outputs.
interface hrange_stepped_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    _start;
    logic signed [WIDTH-1:0] start;
    logic signed [WIDTH-1:0] stop;
    logic signed [WIDTH-1:0] step;
    logic                    _ready;
    logic                    _valid;
    logic                    _done;
    logic                    _error;
    logic signed [WIDTH-1:0] _out0;
    logic        [WIDTH-1:0] _out1;

    modport master (
        output _start, start, stop, step, _ready,
        input  _valid, _done, _error, _out0, _out1
    );

    modport slave (
        input  _start, start, stop, step, _ready,
        output _valid, _done, _error, _out0, _out1
    );
endinterface

// File: rtl/hrange_stepped.sv
// Hardware range(start, stop, step) generator with signed step, optional inclusive
// end and overflow-safe termination; one item per clock under _ready/_valid.
module hrange_stepped #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INCLUSIVE = 0
) (
    input  logic              _clock,
    input  logic              _reset,
    hrange_stepped_if.slave   bus
);
    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic                    done_q,  done_d;
    logic                    error_q, error_d;
    logic signed [WIDTH-1:0] out0_q,  out0_d;
    logic        [WIDTH-1:0] out1_q,  out1_d;
    logic signed [WIDTH-1:0] step_q,  step_d;
    logic signed [WIDTH-1:0] stop_q,  stop_d;
    logic signed [XW-1:0]    nxt;

    function automatic logic signed [XW-1:0] sext(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    // Zero step never yields items; otherwise direction picks the comparison.
    function automatic logic in_range(input logic signed [XW-1:0]    v,
                                      input logic signed [XW-1:0]    lim,
                                      input logic signed [WIDTH-1:0] stp);
        logic pos;
        logic neg;
        pos = !stp[WIDTH-1] && (stp != '0);
        neg = stp[WIDTH-1];
        if (pos) begin
            return (INCLUSIVE != 0) ? (v <= lim) : (v < lim);
        end else if (neg) begin
            return (INCLUSIVE != 0) ? (v >= lim) : (v > lim);
        end
        return 1'b0;
    endfunction

    function automatic logic fits(input logic signed [XW-1:0] v);
        return v[XW-1] == v[XW-2];
    endfunction

    assign nxt = sext(out0_q) + sext(step_q);

    // Next-state: _start wins over everything, then the accept path in RUN.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        error_d = error_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        step_d  = step_q;
        stop_d  = stop_q;
        if (bus._start) begin
            step_d  = bus.step;
            stop_d  = bus.stop;
            error_d = (bus.step == '0);
            if (in_range(sext(bus.start), sext(bus.stop), bus.step)) begin
                out0_d  = bus.start;
                out1_d  = '0;
                valid_d = 1'b1;
                state_d = RUN;
            end else begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && valid_q && bus._ready) begin
            if (in_range(nxt, sext(stop_q), step_q) && fits(nxt)) begin
                out0_d = nxt[WIDTH-1:0];
                out1_d = out1_q + WIDTH'(1);
            end else begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
            step_q  <= '0;
            stop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            error_q <= error_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
        end
    end

    assign bus._valid = valid_q;
    assign bus._done  = done_q;
    assign bus._error = error_q;
    assign bus._out0  = out0_q;
    assign bus._out1  = out1_q;
endmodule

// File: tb/tb_hrange_stepped.sv
// Bench for hrange_stepped: exclusive and inclusive 8-bit instances share stimulus;
// a list-based reference model is compared every cycle, plus hand-computed directed checks.
module tb_hrange_stepped;
    localparam int unsigned W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic go    = 1'b0;
    logic rdy   = 1'b0;
    logic signed [W-1:0] start_v = '0;
    logic signed [W-1:0] stop_v  = '0;
    logic signed [W-1:0] step_v  = '0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    hrange_stepped_if #(.WIDTH(W)) if0 ();
    hrange_stepped_if #(.WIDTH(W)) if1 ();

    hrange_stepped #(.WIDTH(W), .INCLUSIVE(0)) u0 (._clock(clk), ._reset(rst_n), .bus(if0));
    hrange_stepped #(.WIDTH(W), .INCLUSIVE(1)) u1 (._clock(clk), ._reset(rst_n), .bus(if1));

    assign if0._start = go;      assign if1._start = go;
    assign if0.start  = start_v; assign if1.start  = start_v;
    assign if0.stop   = stop_v;  assign if1.stop   = stop_v;
    assign if0.step   = step_v;  assign if1.step   = step_v;
    assign if0._ready = rdy;     assign if1._ready = rdy;

    logic                vld[2];
    logic                dn[2];
    logic                err[2];
    logic signed [W-1:0] o0[2];
    logic        [W-1:0] o1[2];
    assign vld[0] = if0._valid; assign vld[1] = if1._valid;
    assign dn[0]  = if0._done;  assign dn[1]  = if1._done;
    assign err[0] = if0._error; assign err[1] = if1._error;
    assign o0[0]  = if0._out0;  assign o0[1]  = if1._out0;
    assign o1[0]  = if0._out1;  assign o1[1]  = if1._out1;

    always #5 clk = ~clk;

    // Reference model state: the full item list is computed at each start.
    bit     mv[2];
    bit     md[2];
    bit     me[2];
    int     pos[2];
    longint items[2][$];
    longint got[2][$];

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit m_in(input int k, input longint v, input longint e, input longint st);
        if (st > 0) return (k == 1) ? (v <= e) : (v < e);
        if (st < 0) return (k == 1) ? (v >= e) : (v > e);
        return 1'b0;
    endfunction

    function automatic bit m_fits(input longint v);
        return (v >= -128) && (v <= 127);
    endfunction

    initial begin : model
        longint v;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    mv[k] = 1'b0; md[k] = 1'b0; me[k] = 1'b0; pos[k] = 0;
                    items[k].delete();
                end else begin
                    md[k] = 1'b0;
                    if (go) begin
                        items[k].delete();
                        me[k] = (step_v == 0);
                        v = longint'(start_v);
                        if (step_v != 0) begin
                            while (m_in(k, v, longint'(stop_v), longint'(step_v)) && m_fits(v)) begin
                                items[k].push_back(v);
                                v = v + longint'(step_v);
                            end
                        end
                        pos[k] = 0;
                        mv[k]  = (items[k].size() > 0);
                        md[k]  = (items[k].size() == 0);
                    end else if (mv[k] && rdy) begin
                        pos[k] = pos[k] + 1;
                        if (pos[k] >= items[k].size()) begin
                            mv[k] = 1'b0;
                            md[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Record accepted items as seen on the handshake.
    initial forever begin
        @(posedge clk);
        if (rst_n && !go) begin
            for (int k = 0; k < 2; k++)
                if (vld[k] && rdy) got[k].push_back(longint'(o0[k]));
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid%0d", k), longint'(vld[k]), longint'(mv[k]));
                check($sformatf("done%0d", k),  longint'(dn[k]),  longint'(md[k]));
                check($sformatf("error%0d", k), longint'(err[k]), longint'(me[k]));
                if (mv[k]) begin
                    check($sformatf("out0_%0d", k), longint'(o0[k]), items[k][pos[k]]);
                    check($sformatf("out1_%0d", k), longint'(o1[k]), longint'(pos[k]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic do_start(input longint s, input longint e, input longint st);
        @(negedge clk);
        got[0].delete();
        got[1].delete();
        start_v = W'(s);
        stop_v  = W'(e);
        step_v  = W'(st);
        go      = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    // Returns the negedge index (0 = first after the start edge) where _done is seen.
    task automatic wait_done(input int k, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (dn[k]) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) check($sformatf("done_timeout%0d", k), 0, 1);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_arith(input string nm, input int k, input longint first,
                               input longint st, input int n);
        check({nm, "_len"}, longint'(got[k].size()), longint'(n));
        for (int i = 0; i < n && i < got[k].size(); i++)
            check($sformatf("%s_%0d", nm, i), got[k][i], first + longint'(i) * st);
    endtask

    function automatic logic signed [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 8'sh7f;
            1:       return 8'sh80;
            2, 3:    return W'($urandom_range(0, 12)) - W'(6);
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic signed [W-1:0] pick_step();
        case ($urandom_range(0, 9))
            0:          return '0;
            1, 2, 3, 4: return W'($urandom_range(0, 6)) - W'(3);
            default:    return W'($urandom);
        endcase
    endfunction

    initial begin : main
        int c;
        bit pat[12];
        pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};

        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k), longint'(vld[k]), 0);
            check($sformatf("rst_done%0d", k),  longint'(dn[k]),  0);
            check($sformatf("rst_error%0d", k), longint'(err[k]), 0);
            check($sformatf("rst_out0_%0d", k), longint'(o0[k]),  0);
            check($sformatf("rst_out1_%0d", k), longint'(o1[k]),  0);
        end

        // range(0, 10, 1)
        rdy = 1'b1;
        do_start(0, 10, 1);
        wait_done(0, 40, c);
        check("basic_done_cycle", longint'(c), 10);
        settle();
        check_arith("basic_x", 0, 0, 1, 10);
        check_arith("basic_i", 1, 0, 1, 11);

        // range(5, -5, -5)
        do_start(5, -5, -5);
        wait_done(1, 20, c);
        check("neg_done_cycle", longint'(c), 3);
        settle();
        check_arith("neg_i", 1, 5, -5, 3);
        check_arith("neg_x", 0, 5, -5, 2);

        // Backpressure pattern
        rdy = 1'b0;
        do_start(0, 4, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rdy = pat[i];
        end
        rdy = 1'b1;
        settle();
        check_arith("bp_x", 0, 0, 1, 4);
        check_arith("bp_i", 1, 0, 1, 5);

        // Empty range (exclusive) / single item (inclusive)
        do_start(3, 3, 1);
        wait_done(0, 5, c);
        check("empty_done_cycle", longint'(c), 0);
        check("empty_error", longint'(err[0]), 0);
        settle();
        check_arith("empty_x", 0, 3, 1, 0);
        check_arith("empty_i", 1, 3, 1, 1);

        // Zero step
        do_start(7, 20, 0);
        wait_done(0, 5, c);
        check("zstep_done_cycle", longint'(c), 0);
        repeat (4) @(negedge clk);
        #1;
        check("zstep_err0", longint'(err[0]), 1);
        check("zstep_err1", longint'(err[1]), 1);
        do_start(0, 2, 1);
        @(negedge clk);
        #1;
        check("zstep_clear", longint'(err[0]), 0);
        check("zstep_next_valid", longint'(vld[0]), 1);
        settle();

        // Overflow at the 8-bit limit
        do_start(120, 127, 5);
        wait_done(1, 10, c);
        check("ovf_done_cycle", longint'(c), 2);
        settle();
        check_arith("ovf_x", 0, 120, 5, 2);
        check_arith("ovf_i", 1, 120, 5, 2);

        // Restart while item 7 is pending
        rdy = 1'b1;
        do_start(0, 100, 1);
        repeat (8) @(negedge clk);
        rdy = 1'b0;
        #1;
        check("restart_pending", longint'(o0[0]), 7);
        do_start(0, 100, 1);
        @(negedge clk);
        #1;
        check("restart_out0", longint'(o0[0]), 0);
        check("restart_out1", longint'(o1[0]), 0);
        check("restart_valid", longint'(vld[0]), 1);
        rdy = 1'b1;
        wait_done(0, 200, c);
        settle();

        // Asynchronous reset mid-sequence
        do_start(0, 100, 1);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_valid", longint'(vld[0]), 0);
        check("areset_done", longint'(dn[0]), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("areset_stay_idle", longint'(vld[0]), 0);

        // Randomized sequences with random backpressure and occasional restarts
        for (int t = 0; t < 150; t++) begin
            bit idle;
            do_start(longint'(pick_val()), longint'(pick_val()), longint'(pick_step()));
            idle = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                rdy = ($urandom_range(0, 3) != 0);
                if (!mv[0] && !mv[1]) begin
                    idle = 1'b1;
                    break;
                end
                if ($urandom_range(0, 60) == 0) begin
                    idle = 1'b1;
                    break;
                end
            end
            if (!idle) check("rand_timeout", 0, 1);
        end
        rdy = 1'b1;
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hrange_stepped.md
# hrange_stepped

Parametrised successor of the basic range generator: a hardware generator equivalent to Python `range(start, stop, step)`, with a signed step of either sign, an optional inclusive end, and a configurable data width. Items are emitted through the standard `_ready`/`_valid` generator handshake at up to one item per clock with no bubbles. The block is a leaf generator; other generated modules instantiate it inside `for` loops.

## Interface
- `WIDTH`, 32: signed width of `start`, `stop`, `step`, `_out0` and `_out1`.
- `INCLUSIVE`, 0: 0 means `stop` is excluded (Python semantics); 1 means `stop` is emitted if it is hit exactly.
- `_clock`  in  1  sole clock; all logic is on the rising edge.
- `_reset`  in  1  asynchronous, active-low reset.
- `_start`  in  1  captures the arguments on this edge and (re)starts generation.
- `start`  in  WIDTH  signed first value; sampled only when `_start` is high.
- `stop`  in  WIDTH  signed bound; sampled only when `_start` is high.
- `step`  in  WIDTH  signed increment; sampled only when `_start` is high.
- `_ready`  in  1  consumer can accept an item this cycle.
- `_valid`  out  1  `_out0`/`_out1` hold an item.
- `_done`  out  1  one-cycle pulse once the sequence is finished.
- `_error`  out  1  level; set when `step == 0` is captured; cleared by the next `_start`.
- `_out0`  out  WIDTH  current value.
- `_out1`  out  WIDTH  zero-based item index.

## Operation
- **States:** IDLE and RUN.
  - Reset (asynchronous assert) forces IDLE with `_valid=0`, `_done=0`, `_error=0`, `_out0=0`, `_out1=0`, and all internal registers at 0.
- **Start edge.** `_start` has priority over everything else, including a sequence already in progress.
  - Any pending item is discarded.
  - The arguments are latched and `_error` is updated.
  - If the range is empty, the block goes to IDLE and pulses `_done`.
  - Otherwise `_out0=start`, `_out1=0`, `_valid=1`, and the state goes to RUN.
- **Empty range:**
  - `step==0` (this also sets `_error`);
  - `step>0` and `start>=stop`, or `start>stop` when INCLUSIVE;
  - `step<0` and `start<=stop`, or `start<stop` when INCLUSIVE.
- **RUN, item accepted** (`_valid && _ready` at the edge):
  - Compute `nxt = _out0 + step` in WIDTH+1 bits.
  - If `nxt` is still in range and fits in WIDTH signed, set `_out0=nxt`, increment `_out1`, and keep `_valid=1` (no bubble).
  - Otherwise set `_valid=0`, pulse `_done`, and go to IDLE.
- **In-range test for `nxt`:** the same comparisons as the empty-range test, applied to `nxt` instead of `start`, using the WIDTH+1-bit signed value.
  - A signed overflow past the WIDTH limits always ends the sequence. The sequence never wraps.
- **RUN, not accepted** (`_valid && !_ready`): `_out0`, `_out1` and `_valid` are held stable.
- **IDLE:** `_ready` is ignored. Outputs keep their last values and `_valid` stays 0.
- **`_out1`** is a WIDTH-bit unsigned counter. It cannot overflow, because the number of items is at most 2^WIDTH.
- **Reset deasserted mid-sequence:** the block comes out in IDLE and does not resume. Only a new `_start` produces items.

## Timing
- **Latency:** first item valid in the cycle after the `_start` edge.
- **Throughput:** one item per cycle while `_ready` is held high.
- **Completion:** `_done` is high for exactly the one cycle after the edge that accepted the final item. It never coincides with `_valid`.
- **Empty range:** `_done` is high for the one cycle after the `_start` edge.
- **`_start` during `_done`:** legal. The new sequence begins normally and `_done` drops.
- **Handshake rule:** `_valid` never deasserts without a handshake, except on `_start` or reset.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan
- **Basic exclusive range:** `start=0, stop=10, step=1`, `_ready` held high → `_out0` = 0..9 on 10 consecutive cycles, `_out1` = 0..9, `_done` pulses on the next cycle, 11 cycles total after `_start`.
- **Negative step, inclusive:** `INCLUSIVE=1`, `start=5, stop=-5, step=-5` → items 5, 0, -5 with indices 0, 1, 2, then `_done`.
- **Backpressure:** range(0, 4, 1) with `_ready` toggling 1,0,0,1,0,1,1,… → each item is held stable while `_ready=0`, no item is skipped or duplicated, and `_done` comes only after item 3 is accepted.
- **Empty range and zero step:**
  - `start=3, stop=3, step=1` → no `_valid`, `_done` on the cycle after start, `_error=0`.
  - `step=0` → same response, but `_error=1` until the next `_start`.
- **Overflow:** `WIDTH=8`, `start=120, stop=127, step=5`, INCLUSIVE=1 → items 120, 125, then `_done`. 130 does not fit in 8 bits, so the sequence ends with no wrap to a negative value.
- **Restart and reset:**
  - `_start` asserted with range(0, 100, 1) while item 7 is pending → the next item is `start` of the new arguments, with `_out1=0`.
  - Asserting `_reset` low asynchronously mid-sequence → `_valid` and `_done` go to 0 immediately. After release, no output appears until a new `_start`.
